battle_board: RTL and testbench

//  Parametrised ROWSxCOLS Battleship board: stores per-cell ship ID and 2-bit cell state,

---
 rtl/battle_board_if.sv | 24 ++
 rtl/battle_board.sv | 214 +++++++++++++++++++++
 tb/tb_battle_board.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/battle_board_if.sv
// Shot request / result handshake between the shot controller and the board.
// master = controller side, slave = board side.
interface battle_board_if #(
    parameter int RC_W = 4,
    parameter int ID_W = 3
);
    logic            shot_valid;
    logic            shot_ready;
    logic [RC_W-1:0] shot_row;
    logic [RC_W-1:0] shot_col;
    logic            res_valid;
    logic [2:0]      res_code;
    logic [ID_W-1:0] res_ship;

    modport master (
        output shot_valid, shot_row, shot_col,
        input  shot_ready, res_valid, res_code, res_ship
    );

    modport slave (
        input  shot_valid, shot_row, shot_col,
        output shot_ready, res_valid, res_code, res_ship
    );
endinterface

// File: rtl/battle_board.sv
// Battleship board: ship IDs, cell states, shot evaluation, sink marking.
// Define ADJ_MARK_EN to also paint BLUE neighbours of a sunk ship RED.
module battle_board #(
    parameter int ROWS      = 10,
    parameter int COLS      = 10,
    parameter int NUM_SHIPS = 5,
    parameter int ID_W      = 3,
    parameter int RC_W      = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            new_game,
    input  logic            load_valid,
    input  logic [RC_W-1:0] load_row,
    input  logic [RC_W-1:0] load_col,
    input  logic [ID_W-1:0] load_id,
    input  logic            start_game,
    battle_board_if.slave   shot,
    input  logic [RC_W-1:0] rd_row,
    input  logic [RC_W-1:0] rd_col,
    output logic [1:0]      rd_state,
    output logic            game_over
);
    localparam int CNT_W = $clog2(ROWS*COLS+1);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [1:0] BLUE  = 2'b00;
    localparam logic [1:0] GRAY  = 2'b01;
    localparam logic [1:0] BLACK = 2'b10;
    localparam logic [1:0] RED   = 2'b11;

    typedef enum logic [2:0] {
        LOAD, PLAY, EVAL, SINK, OVER
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] id_q  [ROWS][COLS];
    logic [ID_W-1:0] id_d  [ROWS][COLS];
    logic [1:0]      st_q  [ROWS][COLS];
    logic [1:0]      st_d  [ROWS][COLS];
    logic [CNT_W-1:0] cnt_q [1:NUM_SHIPS];
    logic [CNT_W-1:0] cnt_d [1:NUM_SHIPS];
    logic [RC_W-1:0] row_q, row_d, col_q, col_d;
    logic            sink_q, sink_d;
    logic            res_valid_q, res_valid_d;
    logic [2:0]      res_code_q, res_code_d;
    logic [ID_W-1:0] res_ship_q, res_ship_d;
    logic [1:0]      rd_state_q, rd_state_d;

    logic [ID_W-1:0] old_id, hit_id;
    logic            load_ok, shot_ok, rd_ok, left, adj;

    assign shot.shot_ready = (state_q == PLAY);
    assign shot.res_valid  = res_valid_q;
    assign shot.res_code   = res_code_q;
    assign shot.res_ship   = res_ship_q;
    assign rd_state        = rd_state_q;
    assign game_over       = (state_q == OVER);

    assign load_ok = (int'(load_row) < ROWS) && (int'(load_col) < COLS)
                  && (int'(load_id) <= NUM_SHIPS);
    assign shot_ok = (int'(row_q) < ROWS) && (int'(col_q) < COLS);
    assign rd_ok   = (int'(rd_row) < ROWS) && (int'(rd_col) < COLS);

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        st_d        = st_q;
        cnt_d       = cnt_q;
        row_d       = row_q;
        col_d       = col_q;
        sink_d      = sink_q;
        res_valid_d = 1'b0;
        res_code_d  = res_code_q;
        res_ship_d  = res_ship_q;
        rd_state_d  = rd_ok ? st_q[rd_row][rd_col] : BLUE;
        old_id      = '0;
        hit_id      = '0;
        left        = 1'b0;
        adj         = 1'b0;

        unique case (state_q)
            LOAD: begin
                if (load_valid && load_ok) begin
                    old_id = id_q[load_row][load_col];
                    id_d[load_row][load_col] = load_id;
                    if (old_id != load_id) begin
                        if (old_id != '0)
                            cnt_d[old_id] = cnt_d[old_id] - ONE;
                        if (load_id != '0)
                            cnt_d[load_id] = cnt_d[load_id] + ONE;
                    end
                end
                if (start_game) begin
                    for (int i = 1; i <= NUM_SHIPS; i++)
                        if (cnt_d[i] != '0) left = 1'b1;
                    state_d = left ? PLAY : OVER;
                end
            end
            PLAY: begin
                if (shot.shot_valid) begin
                    row_d   = shot.shot_row;
                    col_d   = shot.shot_col;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                res_valid_d = 1'b1;
                res_ship_d  = '0;
                sink_d      = 1'b0;
                state_d     = SINK;
                if (!shot_ok) begin
                    res_code_d = 3'd4;
                end else if (st_q[row_q][col_q] != BLUE) begin
                    res_code_d = 3'd3;
                end else begin
                    hit_id = id_q[row_q][col_q];
                    if (hit_id == '0) begin
                        res_code_d = 3'd0;
                        st_d[row_q][col_q] = GRAY;
                    end else begin
                        cnt_d[hit_id] = cnt_q[hit_id] - ONE;
                        st_d[row_q][col_q] = BLACK;
                        res_ship_d = hit_id;
                        if (cnt_q[hit_id] == ONE) begin
                            res_code_d = 3'd2;
                            sink_d     = 1'b1;
                        end else begin
                            res_code_d = 3'd1;
                        end
                    end
                end
            end
            SINK: begin
                // res_ship_q still holds the ID of the ship that just sank
                if (sink_q) begin
                    for (int r = 0; r < ROWS; r++) begin
                        for (int c = 0; c < COLS; c++) begin
`ifdef ADJ_MARK_EN
                            adj =
                              ((r > 0) &&
                               (id_q[(r>0)?r-1:r][c] == res_ship_q))
                           || ((r < ROWS-1) &&
                               (id_q[(r<ROWS-1)?r+1:r][c] == res_ship_q))
                           || ((c > 0) &&
                               (id_q[r][(c>0)?c-1:c] == res_ship_q))
                           || ((c < COLS-1) &&
                               (id_q[r][(c<COLS-1)?c+1:c] == res_ship_q));
`else
                            adj = 1'b0;
`endif
                            if (id_q[r][c] == res_ship_q)
                                st_d[r][c] = RED;
                            else if (adj && st_q[r][c] == BLUE)
                                st_d[r][c] = RED;
                        end
                    end
                end
                sink_d = 1'b0;
                for (int i = 1; i <= NUM_SHIPS; i++)
                    if (cnt_q[i] != '0) left = 1'b1;
                state_d = left ? PLAY : OVER;
            end
            OVER: begin
                state_d = OVER;
            end
            default: state_d = LOAD;
        endcase

        if (new_game) begin
            state_d     = LOAD;
            res_valid_d = 1'b0;
            sink_d      = 1'b0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin
                    id_d[r][c] = '0;
                    st_d[r][c] = BLUE;
                end
            for (int i = 1; i <= NUM_SHIPS; i++)
                cnt_d[i] = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= LOAD;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin
                    id_q[r][c] <= '0;
                    st_q[r][c] <= BLUE;
                end
            for (int i = 1; i <= NUM_SHIPS; i++)
                cnt_q[i] <= '0;
            row_q       <= '0;
            col_q       <= '0;
            sink_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_code_q  <= 3'd0;
            res_ship_q  <= '0;
            rd_state_q  <= BLUE;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            st_q        <= st_d;
            cnt_q       <= cnt_d;
            row_q       <= row_d;
            col_q       <= col_d;
            sink_q      <= sink_d;
            res_valid_q <= res_valid_d;
            res_code_q  <= res_code_d;
            res_ship_q  <= res_ship_d;
            rd_state_q  <= rd_state_d;
        end
    end
endmodule

// File: tb/tb_battle_board.sv
// Directed bench for battle_board; expectations follow ADJ_MARK_EN.
module tb_battle_board;
`ifdef ADJ_MARK_EN
    localparam logic [1:0] ADJ = 2'b11;
`else
    localparam logic [1:0] ADJ = 2'b00;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       new_game = 1'b0;
    logic       load_valid = 1'b0;
    logic [3:0] load_row = '0, load_col = '0;
    logic [2:0] load_id = '0;
    logic       start_game = 1'b0;
    logic [3:0] rd_row = '0, rd_col = '0;
    logic [1:0] rd_state;
    logic       game_over;
    int         total = 0;
    int         bad = 0;

    battle_board_if #(.RC_W(4), .ID_W(3)) bif ();

    battle_board dut (
        .clk        (clk),
        .reset      (reset),
        .new_game   (new_game),
        .load_valid (load_valid),
        .load_row   (load_row),
        .load_col   (load_col),
        .load_id    (load_id),
        .start_game (start_game),
        .shot       (bif),
        .rd_row     (rd_row),
        .rd_col     (rd_col),
        .rd_state   (rd_state),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int r, input int c, input int id);
        load_valid = 1'b1;
        load_row   = 4'(r);
        load_col   = 4'(c);
        load_id    = 3'(id);
        tick();
        load_valid = 1'b0;
    endtask

    task automatic start();
        start_game = 1'b1;
        tick();
        start_game = 1'b0;
    endtask

    task automatic newg();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
    endtask

    task automatic rd(input int r, input int c,
                      input logic [1:0] exp, input string tag);
        rd_row = 4'(r);
        rd_col = 4'(c);
        tick();
        chk(tag, 32'(rd_state), 32'(exp));
    endtask

    task automatic shoot(input int r, input int c,
                         input int code, input int ship,
                         input string tag);
        chk({tag, "_rdy"}, 32'(bif.shot_ready), 32'd1);
        bif.shot_valid = 1'b1;
        bif.shot_row   = 4'(r);
        bif.shot_col   = 4'(c);
        tick();
        bif.shot_valid = 1'b0;
        chk({tag, "_busy"}, 32'(bif.shot_ready), 32'd0);
        tick();
        chk({tag, "_rv"}, 32'(bif.res_valid), 32'd1);
        chk({tag, "_code"}, 32'(bif.res_code), 32'(code));
        chk({tag, "_ship"}, 32'(bif.res_ship), 32'(ship));
        tick();
        chk({tag, "_rv0"}, 32'(bif.res_valid), 32'd0);
    endtask

    initial begin
        bif.shot_valid = 1'b0;
        bif.shot_row   = '0;
        bif.shot_col   = '0;
        repeat (2) tick();
        chk("rst_ready", 32'(bif.shot_ready), 32'd0);
        chk("rst_rv", 32'(bif.res_valid), 32'd0);
        chk("rst_code", 32'(bif.res_code), 32'd0);
        chk("rst_ship", 32'(bif.res_ship), 32'd0);
        chk("rst_rd", 32'(rd_state), 32'd0);
        chk("rst_go", 32'(game_over), 32'd0);
        reset = 1'b0;
        tick();

        // game 1: ship 1 across (0,0),(0,1)
        load(0, 0, 1);
        load(0, 1, 1);
        start();
        chk("play_ready", 32'(bif.shot_ready), 32'd1);
        shoot(5, 5, 0, 0, "miss");
        rd(5, 5, 2'b01, "miss_gray");
        shoot(5, 5, 3, 0, "repeat");
        rd(5, 5, 2'b01, "repeat_keep");
        shoot(10, 3, 4, 0, "invalid");
        chk("inv_ready_back", 32'(bif.shot_ready), 32'd1);
        rd(0, 0, 2'b00, "inv_no_change");
        shoot(0, 0, 1, 1, "hit");
        rd(0, 0, 2'b10, "hit_black");
        shoot(0, 1, 2, 1, "sunk");
        chk("sunk_go", 32'(game_over), 32'd1);
        chk("sunk_ready", 32'(bif.shot_ready), 32'd0);
        rd(0, 0, 2'b11, "sunk_red00");
        rd(0, 1, 2'b11, "sunk_red01");
        rd(1, 0, ADJ, "sunk_adj10");
        rd(0, 2, ADJ, "sunk_adj02");
        rd(5, 5, 2'b01, "sunk_gray55");

        bif.shot_valid = 1'b1;
        bif.shot_row   = 4'd3;
        bif.shot_col   = 4'd3;
        repeat (3) tick();
        chk("over_no_res", 32'(bif.res_valid), 32'd0);
        bif.shot_valid = 1'b0;

        newg();
        chk("ng_go", 32'(game_over), 32'd0);
        rd(0, 0, 2'b00, "ng_clear");
        start();
        chk("empty_over", 32'(game_over), 32'd1);

        // game 2: ships 2@(4,4), 3@(9,9); other loads cancel out or are dropped
        newg();
        load(4, 4, 2);
        load(9, 9, 3);
        load(2, 2, 4);
        load(2, 2, 0);
        load(7, 7, 6);
        load(10, 0, 1);
        start();
        shoot(7, 7, 0, 0, "bad_id_miss");
        shoot(4, 5, 0, 0, "g2_miss45");
        shoot(4, 4, 2, 2, "g2_sink2");
        chk("g2_go0", 32'(game_over), 32'd0);
        chk("g2_ready", 32'(bif.shot_ready), 32'd1);
        rd(4, 4, 2'b11, "g2_own");
        rd(3, 4, ADJ, "g2_n");
        rd(5, 4, ADJ, "g2_s");
        rd(4, 3, ADJ, "g2_w");
        rd(4, 5, 2'b01, "g2_gray_e");
        rd(3, 3, 2'b00, "g2_diag");
        shoot(2, 2, 0, 0, "g2_cleared");
        shoot(9, 9, 2, 3, "g2_sink3");
        chk("g2_go1", 32'(game_over), 32'd1);
        rd(8, 9, ADJ, "corner_n");
        rd(9, 8, ADJ, "corner_w");
        rd(0, 9, 2'b00, "corner_nowrap_r");
        rd(9, 0, 2'b00, "corner_nowrap_c");
        rd(8, 8, 2'b00, "corner_diag");

        // new_game during EVAL suppresses the result
        newg();
        load(3, 3, 1);
        start();
        bif.shot_valid = 1'b1;
        bif.shot_row   = 4'd3;
        bif.shot_col   = 4'd3;
        tick();
        bif.shot_valid = 1'b0;
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        chk("ng_supp_rv", 32'(bif.res_valid), 32'd0);
        rd(3, 3, 2'b00, "ng_supp_cell");

        // reset while in SINK
        load(1, 1, 1);
        load(6, 6, 2);
        start();
        bif.shot_valid = 1'b1;
        bif.shot_row   = 4'd1;
        bif.shot_col   = 4'd1;
        tick();
        bif.shot_valid = 1'b0;
        tick();
        chk("mid_code", 32'(bif.res_code), 32'd2);
        reset = 1'b1;
        #1;
        chk("mid_ready", 32'(bif.shot_ready), 32'd0);
        chk("mid_go", 32'(game_over), 32'd0);
        chk("mid_rv", 32'(bif.res_valid), 32'd0);
        chk("mid_rd", 32'(rd_state), 32'd0);
        tick();
        reset = 1'b0;
        rd(1, 1, 2'b00, "mid_cell11");
        rd(6, 6, 2'b00, "mid_cell66");
        start();
        chk("mid_load_state", 32'(game_over), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
